// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch controller: boot-loader write port in LOAD, then
// sequential fetch with a one-entry valid/ready output stage, redirects and faults.
//
// state | meaning
// LOAD  | loader owns the memory port, writes pass straight through
// RUN   | pc drives the read address, instructions stream to decode
// HALT  | fetch fault seen, outputs inactive until reset
module imem_fetch_ctrl #(
  parameter int          ADDR_W    = 10,
  parameter int          INSTR_LEN = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load_valid,
  input  logic [ADDR_W-1:0]    i_load_addr,
  input  logic [INSTR_LEN-1:0] i_load_data,
  input  logic                 i_load_done,
  output logic                 o_load_ready,
  output logic [ADDR_W-1:0]    o_mem_addr,
  output logic                 o_mem_we,
  output logic [INSTR_LEN-1:0] o_mem_wdata,
  input  logic [INSTR_LEN-1:0] i_mem_rdata,
  input  logic                 i_redirect_valid,
  input  logic [31:0]          i_redirect_pc,
  output logic                 o_instr_valid,
  output logic [INSTR_LEN-1:0] o_instr,
  output logic [31:0]          o_instr_pc,
  input  logic                 i_instr_ready,
  output logic                 o_fault,
  output logic                 o_running
);

  typedef enum logic [1:0] {LOAD, RUN, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        pc_bad;
  logic        fetch;

  // Anything above the last word or not word-aligned is a fault.
  assign pc_bad = (pc[1:0] != 2'b00) || (pc[31:ADDR_W+2] != '0);
  assign fetch  = !o_instr_valid || i_instr_ready;

  assign o_mem_we    = (state == LOAD) && i_load_valid;
  assign o_mem_addr  = (state == LOAD) ? i_load_addr : pc[ADDR_W+1:2];
  assign o_mem_wdata = i_load_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= LOAD;
      pc            <= RESET_PC;
      o_instr_valid <= 1'b0;
      o_instr       <= '0;
      o_instr_pc    <= '0;
      o_fault       <= 1'b0;
      o_load_ready  <= 1'b1;
      o_running     <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (i_load_done) begin
            state         <= RUN;
            pc            <= RESET_PC;
            o_instr_valid <= 1'b0;
            o_instr       <= '0;
            o_instr_pc    <= '0;
            o_load_ready  <= 1'b0;
            o_running     <= 1'b1;
          end
        end
        RUN: begin
          // A redirect overrides both fetch and the fault check of the old pc.
          if (i_redirect_valid) begin
            o_instr_valid <= 1'b0;
            pc            <= i_redirect_pc;
          end else if (fetch) begin
            if (pc_bad) begin
              o_fault       <= 1'b1;
              o_instr_valid <= 1'b0;
              o_running     <= 1'b0;
              state         <= HALT;
            end else begin
              o_instr_valid <= 1'b1;
              o_instr       <= i_mem_rdata;
              o_instr_pc    <= pc;
              pc            <= pc + 32'd4;
            end
          end
        end
        HALT: begin
          o_instr_valid <= 1'b0;
          o_fault       <= 1'b1;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
